// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / MMIO responder.
package dmem_pkg;
  // Byte offsets inside the peripheral window
  localparam logic [4:0] OFF_TCOUNT = 5'h00;
  localparam logic [4:0] OFF_TCMP   = 5'h04;
  localparam logic [4:0] OFF_TCTRL  = 5'h08;
  localparam logic [4:0] OFF_GPIO   = 5'h0C;
  localparam logic [4:0] OFF_CYCLE  = 5'h10;
  localparam logic [4:0] OFF_STAT   = 5'h14;

  // TCTRL bit positions
  localparam int TEN_BIT   = 0;
  localparam int TAUTO_BIT = 1;
  localparam int TFLAG_BIT = 2;
  localparam int TIE_BIT   = 3;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;
endpackage

// File: rtl/mmio_timer.sv
// 32-bit timer: count, compare, autoreload, sticky flag and interrupt.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_tcount_i,
  input  logic        we_tcmp_i,
  input  logic        we_tctrl_i,
  input  logic [31:0] wd_i,
  output logic [31:0] tcount_o,
  output logic [31:0] tcmp_o,
  output logic [31:0] tctrl_o,
  output logic        irq_o
);
  logic [31:0] tcount_q, tcount_d, tcmp_q;
  logic        ten_q, tauto_q, tie_q, tflag_q, tflag_d, hw_set;

  // Count priority: software load, then match (flag + reload/step), then plain step
  always_comb begin
    tcount_d = tcount_q;
    hw_set   = 1'b0;
    if (we_tcount_i) begin
      tcount_d = wd_i;
    end else if (ten_q && (tcount_q == tcmp_q)) begin
      hw_set   = 1'b1;
      tcount_d = tauto_q ? 32'd0 : tcount_q + 32'd1;
    end else if (ten_q) begin
      tcount_d = tcount_q + 32'd1;
    end
    // A hardware set beats a simultaneous write-1-clear
    tflag_d = hw_set | (tflag_q & ~(we_tctrl_i & wd_i[TFLAG_BIT]));
  end

  // Timer register state
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount_q <= '0;
      tcmp_q   <= '0;
      ten_q    <= 1'b0;
      tauto_q  <= 1'b0;
      tie_q    <= 1'b0;
      tflag_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tflag_q  <= tflag_d;
      if (we_tcmp_i) tcmp_q <= wd_i;
      if (we_tctrl_i) begin
        ten_q   <= wd_i[TEN_BIT];
        tauto_q <= wd_i[TAUTO_BIT];
        tie_q   <= wd_i[TIE_BIT];
      end
    end
  end

  assign tcount_o = tcount_q;
  assign tcmp_o   = tcmp_q;
  assign tctrl_o  = {28'd0, tie_q, tflag_q, tauto_q, ten_q};
  assign irq_o    = tflag_q & tie_q;
endmodule

// File: rtl/dmem_mmio.sv
// Data-memory responder: word RAM plus timer/cycle/GPIO peripheral window.
// Optional build macro DMEM_ALIGN_CHECK_EN adds a sticky misalign flag
// (port misalign, readable at window offset 0x14 bit0).
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       a,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic [GPIO_W-1:0] gpio_out,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic              irq
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       cycle_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [31:0]       tcount, tcmp, tctrl, stat;
  logic [4:0]        off;
  region_e           region;
  logic              mmio_we;

  // Address decode; low two bits never select data
  always_comb begin
    if (a < 32'(RAM_WORDS * 4))            region = REG_RAM;
    else if (a[31:5] == MMIO_BASE[31:5])   region = REG_MMIO;
    else                                   region = REG_NONE;
  end
  assign off     = {a[4:2], 2'b00};
  assign mmio_we = memwrite && (region == REG_MMIO);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;
  // Sticky until reset: any mapped access with a non-word-aligned address
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else if (region != REG_NONE && a[1:0] != 2'b00) misalign_q <= 1'b1;
  end
  assign misalign = misalign_q;
  assign stat     = {31'd0, misalign_q};
`else
  assign stat = '0;
`endif

  // Combinational read mux; stores show up only after the edge
  always_comb begin
    rd = '0;
    if (region == REG_RAM) begin
      rd = ram[a[AW+1:2]];
    end else if (region == REG_MMIO) begin
      case (off)
        OFF_TCOUNT: rd = tcount;
        OFF_TCMP:   rd = tcmp;
        OFF_TCTRL:  rd = tctrl;
        OFF_GPIO:   rd = 32'(gpio_q);
        OFF_CYCLE:  rd = cycle_q;
        OFF_STAT:   rd = stat;
        default:    rd = '0;
      endcase
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (memwrite && region == REG_RAM) ram[a[AW+1:2]] <= wd;
  end

  // Free-running cycle counter and GPIO register
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      gpio_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (mmio_we && off == OFF_GPIO) gpio_q <= wd[GPIO_W-1:0];
    end
  end

  mmio_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .we_tcount_i (mmio_we && off == OFF_TCOUNT),
    .we_tcmp_i   (mmio_we && off == OFF_TCMP),
    .we_tctrl_i  (mmio_we && off == OFF_TCTRL),
    .wd_i        (wd),
    .tcount_o    (tcount),
    .tcmp_o      (tcmp),
    .tctrl_o     (tctrl),
    .irq_o       (irq)
  );

  assign gpio_out = gpio_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized + directed bench for dmem_mmio against a behavioural model.
module tb_dmem_mmio;
  localparam int          RAM_WORDS = 64;
  localparam logic [31:0] MB        = 32'hFFFF_0000;
  localparam int          GPIO_W    = 8;

  logic              clk = 1'b0;
  logic              reset, memwrite;
  logic [31:0]       a, wd, rd;
  logic [GPIO_W-1:0] gpio_out;
  logic              irq;
`ifdef DMEM_ALIGN_CHECK_EN
  logic              misalign;
`endif

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MB), .GPIO_W(GPIO_W)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .a(a), .wd(wd), .rd(rd),
    .gpio_out(gpio_out),
`ifdef DMEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .irq(irq)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] m_ram [RAM_WORDS];
  bit        m_ramv[RAM_WORDS];
  bit [31:0] m_cnt, m_cmp, m_cyc;
  bit [7:0]  m_gpio;
  bit        m_ten, m_auto, m_flag, m_tie, m_mis;

  function automatic int kind(input logic [31:0] ad);  // 0 ram, 1 mmio, 2 none
    if (ad < RAM_WORDS * 4) return 0;
    if (ad[31:5] == MB[31:5]) return 1;
    return 2;
  endfunction

  // Expected read value; known=0 where RAM was never written
  task automatic m_read(input logic [31:0] ad, output bit [31:0] v, output bit known);
    int k = kind(ad);
    known = 1; v = 0;
    if (k == 0) begin
      v = m_ram[ad / 4]; known = m_ramv[ad / 4];
    end else if (k == 1) begin
      case ((ad - MB) / 4)
        0: v = m_cnt;
        1: v = m_cmp;
        2: v = m_ten + 2 * m_auto + 4 * m_flag + 8 * m_tie;
        3: v = m_gpio;
        4: v = m_cyc;
`ifdef DMEM_ALIGN_CHECK_EN
        5: v = m_mis;
`endif
        default: v = 0;
      endcase
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic m_step();
    int  k = kind(a), w = (a - MB) / 4;
    bit  wr_mmio = memwrite && k == 1, hit;
    if (reset) begin
      m_cnt = 0; m_cmp = 0; m_cyc = 0; m_gpio = 0;
      m_ten = 0; m_auto = 0; m_flag = 0; m_tie = 0; m_mis = 0;
      return;
    end
    if (k != 2 && a % 4 != 0) m_mis = 1;
    if (memwrite && k == 0) begin m_ram[a / 4] = wd; m_ramv[a / 4] = 1; end
    hit = 0;
    if (wr_mmio && w == 0)            m_cnt = wd;
    else if (m_ten && m_cnt == m_cmp) begin hit = 1; m_cnt = m_auto ? 0 : m_cnt + 1; end
    else if (m_ten)                   m_cnt = m_cnt + 1;
    if (wr_mmio && w == 2 && wd[2]) m_flag = 0;
    if (hit) m_flag = 1;
    if (wr_mmio && w == 1) m_cmp = wd;
    if (wr_mmio && w == 2) begin m_ten = wd[0]; m_auto = wd[1]; m_tie = wd[3]; end
    if (wr_mmio && w == 3) m_gpio = wd[7:0];
    m_cyc = m_cyc + 1;
  endtask

  // Check outputs for the current inputs, then clock once
  task automatic cyc(input bit rst, input bit we, input logic [31:0] ad, input logic [31:0] d);
    bit [31:0] v; bit known;
    reset = rst; memwrite = we; a = ad; wd = d;
    #1;
    m_read(ad, v, known);
    if (known) chk("rd", rd, v);
    chk("gpio", 32'(gpio_out), 32'(m_gpio));
    chk("irq", 32'(irq), 32'(m_flag & m_tie));
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign", 32'(misalign), 32'(m_mis));
`endif
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d); cyc(0, 1, ad, d); endtask
  task automatic rdc(input logic [31:0] ad); cyc(0, 0, ad, 0); endtask

  initial begin
    reset = 1; memwrite = 0; a = 0; wd = 0;
    @(posedge clk); #1;
    cyc(1, 0, MB, 0);
    // reset state
    a = MB + 32'h08; #1; chk("rst_tctrl", rd, 0);
    a = MB + 32'h10; #1; chk("rst_cycle", rd, 0);
    chk("rst_gpio", 32'(gpio_out), 0);
    chk("rst_irq", 32'(irq), 0);

    // RAM store/load; store cycle still shows old value
    rdc(32'h10);
    wr(32'h10, 32'hDEADBEEF);
    a = 32'h10; #1; chk("ram_10", rd, 32'hDEADBEEF);
    a = 32'h13; #1; chk("ram_13", rd, 32'hDEADBEEF);
    rdc(32'h13);

    // unmapped store is dropped, CYCLE is read-only
    wr(32'h1000, 32'h12345678);
    a = 32'h1000; #1; chk("unmapped", rd, 0);
    wr(MB + 32'h10, 32'h0);
    rdc(MB + 32'h10); rdc(MB + 32'h10);

    // one-shot: TCMP=5, TEN|TIE
    wr(MB + 32'h00, 0);
    wr(MB + 32'h04, 5);
    wr(MB + 32'h08, 32'h9);
    for (int i = 0; i < 9; i++) rdc(MB + 32'h00);
    chk("oneshot_irq", 32'(irq), 1);
    wr(MB + 32'h08, 32'hD);
    chk("clr_irq", 32'(irq), 0);

    // autoreload: TCMP=3, TEN|TAUTO
    wr(MB + 32'h08, 32'h0);
    wr(MB + 32'h00, 0);
    wr(MB + 32'h04, 3);
    wr(MB + 32'h08, 32'h3);
    for (int i = 0; i < 8; i++) rdc(MB + 32'h00);
    a = MB + 32'h08; #1; chk("auto_flag", rd, 32'h7);
    chk("auto_irq", 32'(irq), 0);

    // priority A: TCOUNT write on a match cycle
    wr(MB + 32'h08, 32'h4);           // stop, clear flag
    wr(MB + 32'h00, 7);
    wr(MB + 32'h04, 7);
    wr(MB + 32'h08, 32'h1);           // count sits at 7 == TCMP next cycle
    wr(MB + 32'h00, 100);
    a = MB + 32'h00; #1; chk("prioA_cnt", rd, 100);
    a = MB + 32'h08; #1; chk("prioA_flag", rd, 32'h1);
    // priority B: clear coincides with a match
    wr(MB + 32'h00, 20);
    wr(MB + 32'h04, 21);
    rdc(MB);                          // 21 now, flag sets on next edge
    rdc(MB);                          // flag set, count 22
    wr(MB + 32'h00, 30);
    wr(MB + 32'h04, 31);
    wr(MB + 32'h08, 32'h5);           // count==31==TCMP here: set beats clear
    a = MB + 32'h08; #1; chk("prioB_flag", rd, 32'h5);

    // reset mid-run
    wr(MB + 32'h0C, 32'hA5);
    wr(MB + 32'h00, 50);
    wr(MB + 32'h08, 32'h9);
    rdc(MB); rdc(MB);
    cyc(1, 0, MB, 0);
    chk("mr_gpio", 32'(gpio_out), 0);
    chk("mr_irq", 32'(irq), 0);
    a = MB; #1; chk("mr_cnt", rd, 0);
    a = MB + 32'h10; #1; chk("mr_cyc", rd, 0);
    a = 32'h10; #1; chk("mr_ram", rd, 32'hDEADBEEF);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ad, d;
      int s = $urandom_range(0, 9);
      if (s < 4)      ad = $urandom_range(0, RAM_WORDS * 4 - 1);
      else if (s < 8) ad = MB + $urandom_range(0, 31);
      else if (s < 9) ad = $urandom;
      else            ad = MB - 4 + $urandom_range(0, 40);
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 4, ad, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
